// File: rtl/risco5_mem_pkg.sv
// Shared types and constants for the Risco-5 memory arbitration logic.
// Optional abort-on-timeout behaviour is enabled with ARBITER_TIMEOUT_EN.
package risco5_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Memory access size/sign codes as understood by the Memory block
    localparam logic [2:0] OPT_LB  = 3'b000;
    localparam logic [2:0] OPT_LH  = 3'b001;
    localparam logic [2:0] OPT_LW  = 3'b010;
    localparam logic [2:0] OPT_LBU = 3'b100;
    localparam logic [2:0] OPT_LHU = 3'b101;

    // Load data returned to a master whose transaction was aborted
    localparam logic [31:0] TIMEOUT_READ_DATA = 32'hDEADBEEF;

    // Maps a requester index onto the state that serves it
    function automatic arb_state_t grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// One memory port: request strobes, access attributes and the completion handshake.
// The master modport is the side issuing requests; the slave side answers them.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  memory_read;
    logic                  memory_write;
    logic [2:0]            option;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  memory_response;

    modport master (
        output memory_read,
        output memory_write,
        output option,
        output address,
        output write_data,
        input  read_data,
        input  memory_response
    );

    modport slave (
        input  memory_read,
        input  memory_write,
        input  option,
        input  address,
        input  write_data,
        output read_data,
        output memory_response
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: a lone requester always wins, and when both
// request the one that was not served last time is chosen.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_idx,
    output logic       grant_valid
);

    // Pick a winner from the current request levels and the previous owner
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single Memory port between the Core (m0) and the loader/debug
// master (m1). One transaction at a time, round-robin between requesters,
// with a mandatory IDLE cycle after each completion so a master that drops
// its request after the response is never re-sampled.
// Define ARBITER_TIMEOUT_EN to abort transactions Memory never answers.
module memory_arbiter
    import risco5_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    memory_arbiter_if.slave   m0,
    memory_arbiter_if.slave   m1,
    memory_arbiter_if.master  mem,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("memory_arbiter: TIMEOUT_CYCLES must be within 1..255");
    end

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_grant_q;
    logic       last_grant_d;

    logic [1:0] req;
    logic       pick_idx;
    logic       pick_valid;

    logic                  sel;
    logic                  sel_read;
    logic                  sel_write;
    logic [2:0]            sel_option;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_write_data;

    logic                  abort;
    logic                  complete;
    logic [DATA_WIDTH-1:0] rdata;

    assign req = {m1.memory_read | m1.memory_write,
                  m0.memory_read | m0.memory_write};

    rr_arbiter_2 u_pick (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // Select the attributes of whichever master the current state serves
    always_comb begin
        sel            = (state_q == GRANT1);
        sel_read       = sel ? m1.memory_read  : m0.memory_read;
        sel_write      = sel ? m1.memory_write : m0.memory_write;
        sel_option     = sel ? m1.option       : m0.option;
        sel_address    = sel ? m1.address      : m0.address;
        sel_write_data = sel ? m1.write_data   : m0.write_data;
    end

`ifdef ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] timeout_cnt_q;
    logic [7:0] timeout_cnt_d;

    // Count unanswered grant cycles; abort when the limit is reached unless
    // Memory answers in that very cycle
    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        abort         = 1'b0;
        if (state_q == IDLE) begin
            timeout_cnt_d = '0;
        end else if (!mem.memory_response) begin
            if (timeout_cnt_q == TIMEOUT_LIMIT) begin
                abort = 1'b1;
            end else begin
                timeout_cnt_d = timeout_cnt_q + 8'd1;
            end
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Next-state logic and all bus/handshake outputs; everything idles at 0
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;

        mem.memory_read  = 1'b0;
        mem.memory_write = 1'b0;
        mem.option       = '0;
        mem.address      = '0;
        mem.write_data   = '0;

        m0.memory_response = 1'b0;
        m0.read_data       = '0;
        m1.memory_response = 1'b0;
        m1.read_data       = '0;

        grant_id      = 1'b0;
        busy          = 1'b0;
        timeout_error = 1'b0;
        complete      = 1'b0;
        rdata         = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = grant_state(pick_idx);
                end
            end

            GRANT0, GRANT1: begin
                busy     = 1'b1;
                grant_id = sel;

                mem.memory_write = sel_write;
                mem.memory_read  = sel_read & ~sel_write;
                mem.option       = sel_option;
                mem.address      = sel_address;
                mem.write_data   = sel_write_data;

                complete      = mem.memory_response | abort;
                timeout_error = abort;
                rdata         = abort ? DATA_WIDTH'(TIMEOUT_READ_DATA) : mem.read_data;

                if (sel) begin
                    m1.memory_response = complete;
                    m1.read_data       = rdata;
                end else begin
                    m0.memory_response = complete;
                    m0.read_data       = rdata;
                end

                if (complete) begin
                    state_d      = IDLE;
                    last_grant_d = sel;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and fairness registers; m1 counts as last served so m0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
